// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment scanner:
//   - scan_state_t   : scanner state (IDLE before the first frame, SCAN after)
//   - HEX_SEG_TABLE  : hex nibble to segment pattern, bits g..a with bit0 = a,
//                      active-high (polarity is applied at the top level)
//   - SEG_OFF        : segment pattern of a dark digit, active-high
//   - SEG_DP_OFF     : decimal point off, active-high
// -----------------------------------------------------------------------------
package seven_seg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_OFF    = 7'h00;
   localparam logic       SEG_DP_OFF = 1'b0;

   // Lower-case b and d keep them distinguishable from 8 and 0
   localparam logic [6:0] HEX_SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Purely combinational hex nibble to seven-segment decoder with a blank
// override. Output is active-high; the top level applies pin polarity.
// Ports:
//   i_nibble  in   4  hex value to decode
//   i_blank   in   1  force all segments off
//   o_seg     out  7  segments g..a, bit0 = a
// -----------------------------------------------------------------------------
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   // A blanked digit keeps its anode but shows nothing
   assign o_seg = i_blank ? SEG_OFF : HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexes a bank of common-anode seven-segment digits to show the
// CPU output word in hex. The word, the decimal points and the blanking
// enable are snapshotted once per scan frame so a store mid-frame never
// produces a mixed display.
// Parameters:
//   SCAN_DIV    clock cycles each digit stays lit (>= 2)
//   DIGITS      number of physical digits, 1..8, digit 0 rightmost
//   ACTIVE_LOW  1 inverts Anode, Segment and SegDP at the pins
// Ports:
//   CLK        in   1       system clock
//   Reset      in   1       asynchronous active-high reset
//   Value      in   32      word to display
//   DP         in   8       decimal point enable per digit
//   BlankLZ    in   1       leading-zero blanking enable
//   Anode      out  DIGITS  one-hot digit select
//   Segment    out  7       segments g..a, bit0 = a
//   SegDP      out  1       decimal point of the lit digit
//   FrameTick  out  1       one-cycle pulse after each snapshot (active-high)
// -----------------------------------------------------------------------------
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int SCAN_DIV   = 100000,
   parameter int DIGITS     = 8,
   parameter bit ACTIVE_LOW = 1'b1
)(
   input  logic              CLK,
   input  logic              Reset,
   input  logic [31:0]       Value,
   input  logic [7:0]        DP,
   input  logic              BlankLZ,
   output logic [DIGITS-1:0] Anode,
   output logic [6:0]        Segment,
   output logic              SegDP,
   output logic              FrameTick
);

   localparam int             CNT_W      = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [2:0]     DIGIT_LAST = 3'(DIGITS - 1);

   logic [CNT_W-1:0]  r_count;
   scan_state_t       r_state;
   logic [2:0]        r_digit;
   logic [31:0]       r_value;
   logic [7:0]        r_dp;
   logic              r_blankLZ;
   logic [DIGITS-1:0] r_anode;
   logic [6:0]        r_seg;
   logic              r_segDP;
   logic              r_frameTick;

   logic              w_tick;
   logic              w_snap;
   logic [2:0]        w_nextDigit;
   logic [31:0]       w_value;
   logic [7:0]        w_dp;
   logic              w_blankLZ;
   logic              w_upperZero;
   logic              w_blank;
   logic [3:0]        w_nibble;
   logic [6:0]        w_seg;
   logic [DIGITS-1:0] w_oneHot;

   // Free-running divider; the tick marks the last cycle of each digit slot
   assign w_tick = (r_count == CNT_LAST);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_count <= '0;
      end else if (w_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   // Next digit and snapshot decision; the first tick out of IDLE and every
   // wrap back to digit 0 start a new frame
   always_comb begin
      w_nextDigit = r_digit;
      w_snap      = 1'b0;
      if (w_tick) begin
         case (r_state)
            IDLE: begin
               w_nextDigit = 3'd0;
               w_snap      = 1'b1;
            end
            SCAN: begin
               if (r_digit == DIGIT_LAST) begin
                  w_nextDigit = 3'd0;
                  w_snap      = 1'b1;
               end else begin
                  w_nextDigit = r_digit + 3'd1;
               end
            end
            default: begin
               w_nextDigit = 3'd0;
               w_snap      = 1'b1;
            end
         endcase
      end
   end

   // The registered outputs are loaded from the snapshot that becomes valid
   // on the same edge, so bypass the snapshot registers when one is taken
   assign w_value   = w_snap ? Value   : r_value;
   assign w_dp      = w_snap ? DP      : r_dp;
   assign w_blankLZ = w_snap ? BlankLZ : r_blankLZ;

   // A digit is a leading zero only if it and every higher physical digit
   // are zero; nibbles beyond the physical digit count do not take part
   always_comb begin
      w_upperZero = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if ((i < DIGITS) && (3'(i) >= w_nextDigit) && (w_value[4*i +: 4] != 4'h0)) begin
            w_upperZero = 1'b0;
         end
      end
   end

   assign w_blank  = w_blankLZ && (w_nextDigit != 3'd0) && w_upperZero;
   assign w_nibble = w_value[{w_nextDigit, 2'b00} +: 4];

   hex_to_seg u_hexToSeg (
      .i_nibble (w_nibble),
      .i_blank  (w_blank),
      .o_seg    (w_seg)
   );

   // One-hot anode for the digit about to be lit
   always_comb begin
      w_oneHot = '0;
      for (int d = 0; d < DIGITS; d++) begin
         w_oneHot[d] = (w_nextDigit == 3'(d));
      end
   end

   // Scan state, digit index and frame snapshot
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_digit   <= 3'd0;
         r_value   <= '0;
         r_dp      <= '0;
         r_blankLZ <= 1'b0;
      end else begin
         if (w_tick) begin
            r_state <= SCAN;
            r_digit <= w_nextDigit;
         end
         if (w_snap) begin
            r_value   <= Value;
            r_dp      <= DP;
            r_blankLZ <= BlankLZ;
         end
      end
   end

   // Output registers change only on a tick so each digit is held steady for
   // a whole slot; FrameTick follows the snapshot edge by one cycle
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_anode     <= '0;
         r_seg       <= SEG_OFF;
         r_segDP     <= SEG_DP_OFF;
         r_frameTick <= 1'b0;
      end else begin
         r_frameTick <= w_snap;
         if (w_tick) begin
            r_anode <= w_oneHot;
            r_seg   <= w_seg;
            r_segDP <= w_dp[w_nextDigit];
         end
      end
   end

   // Pin polarity applies to the display drive only, never to FrameTick
   assign Anode     = ACTIVE_LOW ? ~r_anode : r_anode;
   assign Segment   = ACTIVE_LOW ? ~r_seg   : r_seg;
   assign SegDP     = ACTIVE_LOW ? ~r_segDP : r_segDP;
   assign FrameTick = r_frameTick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Directed bench for seven_seg_scanner with SCAN_DIV=4 and ACTIVE_LOW=1.
// An 8-digit instance covers reset, framing, scan order, snapshotting and
// blanking; a 4-digit instance on the same inputs covers ignored nibbles.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

   localparam int SD = 4;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] value = 32'h0;
   logic [7:0]  dp = 8'h0;
   logic        blankLZ = 1'b0;

   logic [7:0]  anode8;
   logic [6:0]  seg8;
   logic        segDP8;
   logic        frame8;
   logic [3:0]  anode4;
   logic [6:0]  seg4;
   logic        segDP4;
   logic        frame4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seven_seg_scanner #(.SCAN_DIV(SD), .DIGITS(8), .ACTIVE_LOW(1'b1)) u_dut8 (
      .CLK       (clk),
      .Reset     (rst),
      .Value     (value),
      .DP        (dp),
      .BlankLZ   (blankLZ),
      .Anode     (anode8),
      .Segment   (seg8),
      .SegDP     (segDP8),
      .FrameTick (frame8)
   );

   seven_seg_scanner #(.SCAN_DIV(SD), .DIGITS(4), .ACTIVE_LOW(1'b1)) u_dut4 (
      .CLK       (clk),
      .Reset     (rst),
      .Value     (value),
      .DP        (dp),
      .BlankLZ   (blankLZ),
      .Anode     (anode4),
      .Segment   (seg4),
      .SegDP     (segDP4),
      .FrameTick (frame4)
   );

   // Advance to just after the next rising edge
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Assert reset mid-cycle, load the inputs, release on the falling edge
   task automatic applyStimulus(input logic [31:0] v, input logic [7:0] d, input logic b);
      @(posedge clk);
      #3;
      rst = 1'b1;
      value = v;
      dp = d;
      blankLZ = b;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus(32'h1234ABCD, 8'h00, 1'b0);
      repeat (6) stepEdge();
      vectors++;
      if (anode8 !== 8'hFE) begin
         miscompares++;
         $display("[TB] FAIL reset_prelit anode got %h expected fe", anode8);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (anode8 !== 8'hFF) begin
         miscompares++;
         $display("[TB] FAIL reset_async anode got %h expected ff", anode8);
      end
      vectors++;
      if (seg8 !== 7'h7F) begin
         miscompares++;
         $display("[TB] FAIL reset_async segment got %h expected 7f", seg8);
      end
      vectors++;
      if (segDP8 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_async segdp got %b expected 1", segDP8);
      end
      vectors++;
      if (frame8 !== 1'b0 || anode4 !== 4'hF) begin
         miscompares++;
         $display("[TB] FAIL reset_async frametick/anode4 got %b/%h expected 0/f", frame8, anode4);
      end
      stepEdge();
      vectors++;
      if (anode8 !== 8'hFF || seg8 !== 7'h7F) begin
         miscompares++;
         $display("[TB] FAIL reset_held anode/segment got %h/%h expected ff/7f", anode8, seg8);
      end
   endtask

   task automatic test_first_frame();
      logic [7:0] expA;
      logic [6:0] expS;
      logic       expF;
      applyStimulus(32'h1234ABCD, 8'h00, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         stepEdge();
         if (e < 4) begin
            expA = 8'hFF; expS = 7'h7F;
         end else if (e < 8) begin
            expA = 8'hFE; expS = ~7'h5E;
         end else begin
            expA = 8'hFD; expS = ~7'h39;
         end
         expF = (e == 4);
         vectors++;
         if (anode8 !== expA) begin
            miscompares++;
            $display("[TB] FAIL first_frame anode edge %0d got %h expected %h", e, anode8, expA);
         end
         vectors++;
         if (seg8 !== expS) begin
            miscompares++;
            $display("[TB] FAIL first_frame segment edge %0d got %h expected %h", e, seg8, expS);
         end
         vectors++;
         if (frame8 !== expF) begin
            miscompares++;
            $display("[TB] FAIL first_frame frametick edge %0d got %b expected %b", e, frame8, expF);
         end
      end
   endtask

   task automatic test_full_frame();
      logic [31:0] v;
      logic [7:0]  expA;
      logic [6:0]  expS;
      logic        expF;
      int          d;
      v = 32'h1234ABCD;
      applyStimulus(v, 8'h00, 1'b0);
      for (int e = 1; e <= 72; e++) begin
         stepEdge();
         if (e < 4) continue;
         d = ((e - 4) / SD) % 8;
         expA = ~(8'h01 << d);
         expS = ~SEG_TAB[v[4*d +: 4]];
         expF = (((e - 4) % 32) == 0);
         vectors++;
         if (anode8 !== expA || seg8 !== expS) begin
            miscompares++;
            $display("[TB] FAIL full_frame anode/segment edge %0d got %h/%h expected %h/%h", e, anode8, seg8, expA, expS);
         end
         vectors++;
         if (frame8 !== expF || segDP8 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_frame frametick/segdp edge %0d got %b/%b expected %b/1", e, frame8, segDP8, expF);
         end
      end
   endtask

   task automatic test_no_tearing();
      logic [31:0] v;
      logic [7:0]  expA;
      logic [6:0]  expS;
      int          d;
      applyStimulus(32'h1234ABCD, 8'h00, 1'b0);
      for (int e = 1; e <= 67; e++) begin
         stepEdge();
         if (e >= 4) begin
            v = (e < 36) ? 32'h1234ABCD : 32'hFFFFFFFF;
            d = ((e - 4) / SD) % 8;
            expA = ~(8'h01 << d);
            expS = ~SEG_TAB[v[4*d +: 4]];
            vectors++;
            if (anode8 !== expA || seg8 !== expS) begin
               miscompares++;
               $display("[TB] FAIL no_tearing anode/segment edge %0d got %h/%h expected %h/%h", e, anode8, seg8, expA, expS);
            end
         end
         if (e == 17) value = 32'hFFFFFFFF;
      end
   endtask

   task automatic test_blanking();
      logic [7:0] expA;
      logic [6:0] expS;
      logic       expP;
      applyStimulus(32'h000000A0, 8'h04, 1'b1);
      for (int d = 0; d < 8; d++) begin
         repeat (SD) stepEdge();
         expA = ~(8'h01 << d);
         expS = (d >= 2) ? 7'h7F : ((d == 1) ? ~7'h77 : ~7'h3F);
         expP = (d == 2) ? 1'b0 : 1'b1;
         vectors++;
         if (anode8 !== expA) begin
            miscompares++;
            $display("[TB] FAIL blanking anode digit %0d got %h expected %h", d, anode8, expA);
         end
         vectors++;
         if (seg8 !== expS) begin
            miscompares++;
            $display("[TB] FAIL blanking segment digit %0d got %h expected %h", d, seg8, expS);
         end
         vectors++;
         if (segDP8 !== expP) begin
            miscompares++;
            $display("[TB] FAIL blanking segdp digit %0d got %b expected %b", d, segDP8, expP);
         end
      end
   endtask

   task automatic test_all_zero();
      logic [6:0] expS;
      applyStimulus(32'h00000000, 8'h00, 1'b1);
      for (int d = 0; d < 8; d++) begin
         repeat (SD) stepEdge();
         expS = (d == 0) ? ~7'h3F : 7'h7F;
         vectors++;
         if (seg8 !== expS || anode8 !== ~(8'h01 << d)) begin
            miscompares++;
            $display("[TB] FAIL all_zero segment/anode digit %0d got %h/%h expected %h", d, seg8, anode8, expS);
         end
      end
   endtask

   task automatic test_digits4();
      logic [3:0] expA;
      logic [6:0] expS;
      logic       expF;
      int         dd;
      applyStimulus(32'hABCD0000, 8'h00, 1'b1);
      for (int d = 0; d <= 4; d++) begin
         repeat (SD) stepEdge();
         dd = d % 4;
         expA = ~(4'h1 << dd);
         expS = (dd == 0) ? ~7'h3F : 7'h7F;
         expF = (dd == 0);
         vectors++;
         if (anode4 !== expA || seg4 !== expS) begin
            miscompares++;
            $display("[TB] FAIL digits4 anode/segment slot %0d got %h/%h expected %h/%h", d, anode4, seg4, expA, expS);
         end
         vectors++;
         if (frame4 !== expF) begin
            miscompares++;
            $display("[TB] FAIL digits4 frametick slot %0d got %b expected %b", d, frame4, expF);
         end
      end
   endtask

   // Scenarios run back to back; each starts from its own reset
   initial begin
      $display("[TB] seven_seg_scanner bench start");
      test_reset();
      test_first_frame();
      test_full_frame();
      test_no_tearing();
      test_blanking();
      test_all_zero();
      test_digits4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Downstream consumer of the CPU's memory-mapped output word (CPUOut). It drives a time-multiplexed bank of common-anode seven-segment digits on the FPGA board, showing the 32-bit word as up to 8 hex digits. The display value is captured once per scan frame so a CPU store mid-frame never produces a torn display. It sits beside the risc_v top in the board wrapper, on the same clock.

Parameters:
SCAN_DIV, 100000, clock cycles each digit is lit (must be >= 2)
DIGITS, 8, number of physical digits driven, 1..8; nibble i maps to digit i, with digit 0 rightmost
ACTIVE_LOW, 1, 1 means Anode, Segment and SegDP are inverted at the pins

Ports:
CLK  input  1  system clock, shared with the CPU
Reset  input  1  asynchronous, active-high reset
Value  input  32  word to display, connected to CPUOut
DP  input  8  decimal-point enable per digit, bit i for digit i
BlankLZ  input  1  enables leading-zero blanking
Anode  output  DIGITS  one-hot digit select (polarity set by ACTIVE_LOW)
Segment  output  7  segments g..a, bit0 = a (polarity set by ACTIVE_LOW)
SegDP  output  1  decimal point for the lit digit (polarity set by ACTIVE_LOW)
FrameTick  output  1  one-cycle pulse when a new snapshot is loaded

Behaviour:
- Clock and reset: one clock (CLK); Reset is asynchronous and active-high. All state is cleared on Reset assertion, with no wait for a CLK edge.
- Reset values:
  - divider count = 0; digit index = 0; state = IDLE.
  - Snapshot registers for Value, DP and BlankLZ = 0.
  - All outputs inactive: Anode all off, Segment all off, SegDP off (with ACTIVE_LOW=1 this is all ones), FrameTick = 0.
- Divider:
  - Count increments every cycle.
  - At count == SCAN_DIV-1 an internal Tick fires and the count wraps to 0.
  - The first Tick after Reset release comes on the SCAN_DIV-th rising edge.
- State machine (IDLE, SCAN):
  - IDLE: outputs stay inactive. On Tick, go to SCAN with digit index = 0 and take a snapshot.
  - SCAN: on Tick, digit index advances by 1, wrapping from DIGITS-1 to 0. Every wrap to 0 takes a snapshot.
- Snapshot:
  - Value, DP and BlankLZ are registered together on the snapshot edge.
  - FrameTick is high for exactly the cycle after that edge.
  - Input changes between snapshots have no visible effect.
- Outputs:
  - Outputs are registered and are loaded on the same Tick edge as the new digit index, from the new index and the new snapshot.
  - Outputs are held constant for SCAN_DIV cycles.
  - Exactly one Anode bit is active in SCAN.
- Decode: the nibble snapshot[4i+3:4i] is hex-decoded to segments g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking:
  - Digit i > 0 is blanked (all segments off) when the snapshot BlankLZ = 1 and every nibble from i up to DIGITS-1 is zero.
  - Digit 0 is never blanked.
  - The anode of a blanked digit still asserts.
  - SegDP follows the snapshot DP[i] regardless of blanking.
- Nibbles at index >= DIGITS are ignored, both for display and for blanking.
- Reset mid-frame: return immediately to IDLE with outputs inactive. The next snapshot is on the SCAN_DIV-th edge after release.
- ACTIVE_LOW inverts Anode, Segment and SegDP only. FrameTick is always active-high.

Decomposition:
- Package seven_seg_pkg holds:
  - scan_state_t enum {IDLE, SCAN}.
  - The 16-entry hex-to-segment constant table (logic [6:0]).
  - Constants SEG_OFF = 7'h00 and SEG_DP_OFF = 1'b0, both pre-polarity.
- One combinational sub-module, hex_to_seg (4-bit nibble + blank in, 7-bit segments out), instantiated once on the muxed nibble.

Test Plan:
- Reset behaviour (SCAN_DIV=4, DIGITS=8, ACTIVE_LOW=1): assert Reset mid-cycle -> Anode=FF, Segment=7F, SegDP=1 immediately.
- First frame: release Reset with Value=32'h1234ABCD -> edges 1-3 stay inactive; edge 4 gives Anode=FE, Segment=~5E (d), FrameTick=1 for one cycle; edge 8 gives Anode=FD, Segment=~39 (C).
- Full-frame order: over 32 cycles, digits 0..7 show D,C,B,A,4,3,2,1 in order; FrameTick pulses exactly every 32 cycles.
- No tearing: change Value to 32'hFFFFFFFF while digit 3 is lit -> digits 4..7 still show 4,3,2,1; the next frame shows F on all digits.
- Leading-zero blanking: Value=32'h000000A0, BlankLZ=1, DP=8'h04 -> digits 7..2 have Segment=7F; digit 2 has SegDP=0 (lit); digit 1 shows A; digit 0 shows 0.
- Value=0, BlankLZ=1 -> only digit 0 shows 0; with DIGITS=4, the nibble at bits [31:16] never affects output.
